rv32i_reg_dbg_access: RTL

RV32I_REG_DBG_ACCESS -- requirements
Module: rv32i_reg_dbg_access

---
 rtl/rv32i_reg_dbg_access_pkg.sv | 17 +
 rtl/rv32i_reg_dbg_access.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rv32i_reg_dbg_access_pkg.sv
// Shared rv32i definitions used by the debug register-access block:
// default datapath sizes and the debug FSM state encoding.
package rv32i_reg_dbg_access_pkg;

    localparam int unsigned RV_XLEN     = 32;
    localparam int unsigned RV_NUM_REGS = 16;
    localparam int unsigned RV_ADDR_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RESP    = 3'd3,
        ST_RELEASE = 3'd4
    } dbg_state_e;

endpackage

// File: rtl/rv32i_reg_dbg_access.sv
// Debug-port access to the RV32E register file: halts the core, performs a
// single read/write or a full dump, and returns responses over valid/ready.
module rv32i_reg_dbg_access
    import rv32i_reg_dbg_access_pkg::*;
#(
    parameter int unsigned XLEN         = RV_XLEN,
    parameter int unsigned NUM_REGS     = RV_NUM_REGS,
    parameter int unsigned ADDR_W       = RV_ADDR_W,
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_dump,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              core_halt_req,
    input  logic              core_halted,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]   rf_rdata,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              rf_we,
    output logic              busy
);

    localparam int unsigned       CNT_W     = $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(HALT_TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    dbg_state_e        state_q;
    logic              write_q;
    logic              dump_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic              rsp_last_q;
    logic              rsp_err_q;
    logic              in_access;
    logic              do_write;

    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // NOTE: control outputs are pure decodes of the registered state, so an
    // asynchronous reset drops them in the same instant the state clears.
    assign in_access     = (state_q == ST_ACCESS);
    assign do_write      = in_access && write_q;
    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign rsp_valid     = (state_q == ST_RESP);
    assign core_halt_req = state_q inside {ST_HALT, ST_ACCESS, ST_RESP};
    assign rf_raddr      = in_access ? addr_q : '0;
    assign rf_waddr      = do_write ? addr_q : '0;
    assign rf_wdata      = do_write ? wdata_q : '0;
    assign rf_we         = do_write && (addr_q != '0);
    assign rsp_addr      = rsp_addr_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_last      = rsp_last_q;
    assign rsp_err       = rsp_err_q;

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            dump_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write && !req_dump;
                        dump_q  <= req_dump;
                        addr_q  <= req_dump ? '0 : req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= '0;
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (core_halted) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_MAX) begin
                            rsp_addr_q <= addr_q;
                            rsp_data_q <= '0;
                            rsp_last_q <= 1'b1;
                            rsp_err_q  <= 1'b1;
                            state_q    <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    rsp_addr_q <= addr_q;
                    rsp_data_q <= (write_q || addr_q == '0) ? '0 : rf_rdata;
                    rsp_last_q <= !dump_q || (addr_q == LAST_ADDR);
                    rsp_err_q  <= 1'b0;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        // A timeout ends a dump early; otherwise walk to the last register.
                        if (dump_q && !rsp_err_q && addr_q != LAST_ADDR) begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= ST_ACCESS;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
